detect_arbiter: RTL and testbench

Round-robin controller that shares one 0110 sequence detector (non-overlapping Moore detector, asynchronous active-high reset, registered state, `out` high while in the match state) among N serial requesters. For each granted frame it clears the detector, streams the requester's bits into it for a programmed length, and counts detector matches. It then reports the count and channel ID with a one-cycle done pulse. It sits between the serial front-end channels and the single detector instance.

---
 rtl/detect_arbiter_pkg.sv | 26 ++
 rtl/detect_arbiter_rr_pick.sv | 41 ++++
 rtl/detect_arbiter.sv | 154 +++++++++++++++
 tb/tb_detect_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_arbiter_pkg.sv
// ============================================================================
// Module   : detect_arbiter_pkg
// Brief    : Shared types and constants for the detect_arbiter block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package detect_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FEED   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    localparam int         C_DEF_N_CH  = 4;
    localparam int         C_DEF_LEN_W = 8;
    localparam int         C_DEF_CNT_W = 8;
    // Sequence recognised by the shared detector, first bit in the MSB.
    localparam logic [3:0] C_PATTERN   = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/detect_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first request at or after ptr.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import detect_arbiter_pkg::*;
#(
    parameter int N     = C_DEF_N_CH,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             valid
);

    logic [PTR_W:0] w_idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single subtraction wraps the index.
            w_idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N)) begin
                w_idx = w_idx - (PTR_W+1)'(N);
            end
            if (!valid && req[w_idx[PTR_W-1:0]]) begin
                pick[w_idx[PTR_W-1:0]] = 1'b1;
                valid                  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/detect_arbiter.sv
// ============================================================================
// Module   : detect_arbiter
// Brief    : Round-robin sharing of one 0110 detector among N serial channels.
// Revision : 1.0
// ============================================================================
`default_nettype none

module detect_arbiter
    import detect_arbiter_pkg::*;
#(
    parameter  int N_CH  = C_DEF_N_CH,
    parameter  int LEN_W = C_DEF_LEN_W,
    parameter  int CNT_W = C_DEF_CNT_W,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  req,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [N_CH-1:0]  ch_bit,
    output logic [N_CH-1:0]  gnt,
    output logic             det_in,
    output logic             det_reset,
    input  logic             det_out,
    output logic             done,
    output logic [CH_W-1:0]  done_ch,
    output logic [CNT_W-1:0] match_count
);

    state_t           r_state;
    state_t           w_next;
    logic [CH_W-1:0]  r_ch;
    logic [CH_W-1:0]  r_ptr;
    logic [LEN_W-1:0] r_remain;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_counting;
    logic             r_det_reset;
    logic             r_done;
    logic [CH_W-1:0]  r_done_ch;
    logic [CNT_W-1:0] r_match_count;
    logic [N_CH-1:0]  w_pick;
    logic             w_valid;
    logic [CH_W-1:0]  w_pick_idx;

    rr_pick #(
        .N     (N_CH),
        .PTR_W (CH_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .pick  (w_pick),
        .valid (w_valid)
    );

    always_comb begin
        w_pick_idx = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_pick[k]) begin
                w_pick_idx = CH_W'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        gnt    = '0;
        det_in = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                gnt    = N_CH'(1) << r_ch;
                w_next = (r_remain != '0) ? ST_FEED : ST_REPORT;
            end
            ST_FEED: begin
                gnt    = N_CH'(1) << r_ch;
                det_in = ch_bit[r_ch];
                if (r_remain == LEN_W'(1)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                gnt    = N_CH'(1) << r_ch;
                w_next = ST_REPORT;
            end
            ST_REPORT: begin
                gnt    = N_CH'(1) << r_ch;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign w_counting  = ((r_state == ST_FEED) || (r_state == ST_DRAIN)) && det_out;
    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ch          <= '0;
            r_ptr         <= '0;
            r_remain      <= '0;
            r_count       <= '0;
            r_det_reset   <= 1'b1;
            r_done        <= 1'b0;
            r_done_ch     <= '0;
            r_match_count <= '0;
        end else begin
            // Decoded from the next state so the detector reset is a clean flop output.
            r_det_reset <= !((w_next == ST_FEED) || (w_next == ST_DRAIN));
            r_done      <= (w_next == ST_REPORT);
            if ((r_state == ST_IDLE) && w_valid) begin
                r_ch     <= w_pick_idx;
                r_remain <= frame_len;
                r_count  <= '0;
            end
            if (r_state == ST_FEED) begin
                r_remain <= r_remain - LEN_W'(1);
            end
            if (w_counting) begin
                r_count <= w_count_inc;
            end
            // The final DRAIN-edge match is folded in while loading the report.
            if (w_next == ST_REPORT) begin
                r_done_ch     <= r_ch;
                r_match_count <= w_counting ? w_count_inc : r_count;
            end
            if (r_state == ST_REPORT) begin
                r_ptr <= (r_ch == CH_W'(N_CH - 1)) ? '0 : r_ch + CH_W'(1);
            end
        end
    end

    assign det_reset   = r_det_reset;
    assign done        = r_done;
    assign done_ch     = r_done_ch;
    assign match_count = r_match_count;

endmodule

`default_nettype wire

// File: tb/tb_detect_arbiter.sv
// ============================================================================
// Module   : tb_detect_arbiter
// Brief    : Self-checking bench for detect_arbiter with a behavioural detector.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_detect_arbiter;
    import detect_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] frame_len = '0;
    logic [3:0] ch_bit = '0;
    logic [3:0] gnt;
    logic       det_in, det_reset, det_out, done;
    logic [1:0] done_ch;
    logic [7:0] match_count;

    logic [3:0] s_req = '0;
    logic [7:0] s_len = '0;
    logic [3:0] s_ch_bit = '0;
    logic [3:0] s_gnt;
    logic       s_det_in, s_det_reset, s_det_out, s_done;
    logic [1:0] s_done_ch;
    logic [1:0] s_match;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    detect_arbiter #(.N_CH(4), .LEN_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .req(req), .frame_len(frame_len), .ch_bit(ch_bit),
        .gnt(gnt), .det_in(det_in), .det_reset(det_reset), .det_out(det_out),
        .done(done), .done_ch(done_ch), .match_count(match_count)
    );

    detect_arbiter #(.N_CH(4), .LEN_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .req(s_req), .frame_len(s_len), .ch_bit(s_ch_bit),
        .gnt(s_gnt), .det_in(s_det_in), .det_reset(s_det_reset), .det_out(s_det_out),
        .done(s_done), .done_ch(s_done_ch), .match_count(s_match)
    );

    // Detector environment: progress = pattern bits matched so far, 4 = match state.
    function automatic logic [2:0] det_step(input logic [2:0] p, input logic b);
        logic [3:0] pat;
        int         pos;
        pat = C_PATTERN;
        pos = (p == 3'd4) ? 0 : int'(p);
        if (b == pat[3 - pos]) return 3'(pos + 1);
        return (b == pat[3]) ? 3'd1 : 3'd0;
    endfunction

    logic [2:0] det_p, s_det_p;
    always @(posedge clk or posedge det_reset) begin
        if (det_reset) det_p <= 3'd0;
        else           det_p <= det_step(det_p, det_in);
    end
    always @(posedge clk or posedge s_det_reset) begin
        if (s_det_reset) s_det_p <= 3'd0;
        else             s_det_p <= det_step(s_det_p, s_det_in);
    end
    assign det_out   = (det_p == 3'd4);
    assign s_det_out = (s_det_p == 3'd4);

    // Reference: greedy left-to-right non-overlapping search, saturated.
    function automatic int count_matches(input logic [63:0] bits, input int len, input int maxv);
        logic [3:0] pat;
        int n, i;
        pat = C_PATTERN;
        n = 0;
        i = 0;
        while (i + 4 <= len) begin
            if (bits[i] == pat[3] && bits[i+1] == pat[2] && bits[i+2] == pat[1] && bits[i+3] == pat[0]) begin
                n++;
                i += 4;
            end else begin
                i++;
            end
        end
        return (n > maxv) ? maxv : n;
    endfunction

    function automatic int rr_expect(input logic [3:0] rq, input int p);
        for (int k = 0; k < 4; k++) begin
            if (rq[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; leaves the bench in the IDLE cycle after REPORT.
    task automatic run_frame(input logic [3:0] rq, input int len, input logic [63:0] bits,
                             input int exp_ch, input int exp_cnt, input bit drop);
        int waited;
        int low_cycles;
        req       = rq;
        frame_len = len[7:0];
        waited    = 0;
        while (gnt == '0 && waited < 6) begin
            step();
            waited++;
        end
        chk("grant", 32'(gnt), 32'(1) << exp_ch);
        chk("clear_det_reset", 32'(det_reset), 1);
        chk("clear_det_in", 32'(det_in), 0);
        if (drop) req = '0;
        low_cycles = 0;
        for (int k = 0; k < len; k++) begin
            step();
            ch_bit         = 4'($urandom);
            ch_bit[exp_ch] = bits[k];
            #1;
            if (det_reset == 1'b0) low_cycles++;
            chk("feed_gnt", 32'(gnt), 32'(1) << exp_ch);
            chk("feed_det_in", 32'(det_in), 32'(bits[k]));
            chk("feed_done", 32'(done), 0);
        end
        if (len > 0) begin
            step();
            ch_bit = 4'($urandom);
            #1;
            if (det_reset == 1'b0) low_cycles++;
            chk("drain_det_in", 32'(det_in), 0);
        end
        step();
        chk("done", 32'(done), 1);
        chk("done_ch", 32'(done_ch), exp_ch);
        chk("match_count", 32'(match_count), exp_cnt);
        chk("report_det_reset", 32'(det_reset), 1);
        chk("det_reset_low_cycles", low_cycles, (len > 0) ? len + 1 : 0);
        step();
        chk("idle_done", 32'(done), 0);
        chk("idle_gnt", 32'(gnt), 0);
        chk("held_match_count", 32'(match_count), exp_cnt);
    endtask

    typedef struct {
        logic [3:0]  rq;
        int          ch;
        int          len;
        logic [63:0] bits;
        int          exp_cnt;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int          ptr;
        int          ch, len, cnt, done_seen;
        logic [3:0]  rq;
        logic [3:0]  pat;
        logic [63:0] bits;

        // bits[k] is the k-th bit streamed into the detector.
        tbl[0] = '{4'b0001, 0, 4, 64'b0110,          1};
        tbl[1] = '{4'b0100, 2, 8, 64'b01100110,      2};
        tbl[2] = '{4'b0100, 2, 7, 64'b0110110,       1};
        tbl[3] = '{4'b1000, 3, 6, 64'b111111,        0};
        tbl[4] = '{4'b0001, 0, 9, 64'b011011010,     1};
        tbl[5] = '{4'b0010, 1, 5, 64'b01100,         1};
        tbl[6] = '{4'b0010, 1, 0, 64'b0,             0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_det_reset", 32'(det_reset), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_ch", 32'(done_ch), 0);
        chk("rst_match_count", 32'(match_count), 0);
        chk("rst_det_in", 32'(det_in), 0);
        reset = 1'b0;
        step();

        foreach (tbl[i]) begin
            run_frame(tbl[i].rq, tbl[i].len, tbl[i].bits, tbl[i].ch, tbl[i].exp_cnt, 1'b0);
        end

        // Reset in the 3rd FEED cycle of a ch2 frame.
        req       = 4'b0100;
        frame_len = 8'd8;
        step();
        chk("rst_test_grant", 32'(gnt), 32'b0100);
        repeat (3) step();
        reset = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt), 0);
        chk("midrst_det_reset", 32'(det_reset), 1);
        chk("midrst_done", 32'(done), 0);
        req = '0;
        step();
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);

        // Round robin with a held request set; pointer restarts at 0 after reset.
        ptr = 0;
        for (int k = 0; k < 4; k++) begin
            bits = {$urandom, $urandom};
            ch   = rr_expect(4'b1011, ptr);
            run_frame(4'b1011, 4, bits, ch, count_matches(bits, 4, 255), 1'b0);
            ptr = (ch + 1) % 4;
        end

        for (int it = 0; it < 40; it++) begin
            rq   = 4'($urandom_range(1, 15));
            len  = $urandom_range(0, 12);
            bits = {$urandom, $urandom};
            ch   = rr_expect(rq, ptr);
            cnt  = count_matches(bits, len, 255);
            run_frame(rq, len, bits, ch, cnt, $urandom_range(0, 3) == 0);
            ptr = (ch + 1) % 4;
        end
        req = '0;

        // Saturation on the 2-bit counter instance: 8 matches clamp to 3.
        pat   = C_PATTERN;
        s_req = 4'b0001;
        s_len = 8'd32;
        step();
        chk("sat_grant", 32'(s_gnt), 1);
        for (int k = 0; k < 32; k++) begin
            step();
            s_ch_bit[0] = pat[3 - (k % 4)];
        end
        s_req = '0;
        step();
        step();
        chk("sat_done", 32'(s_done), 1);
        chk("sat_match_count", 32'(s_match), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
